// File: rtl/guess_pkg.sv
// Shared types and helpers for the number-guessing round controller.
`default_nettype none

package guess_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    WAIT_GUESS = 3'd2,
    COMPARE    = 3'd3,
    RESOLVE    = 3'd4,
    DONE       = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    EQ   = 2'd1,
    HIGH = 2'd2
  } cmp_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Index 0 is digit_1 (least significant), index 2 is digit_3.
  typedef logic [2:0][3:0] bcd3_t;

  // Digits beyond the active difficulty are treated as zero.
  function automatic bcd3_t mask_digits(input bcd3_t g, input logic [1:0] md);
    bcd3_t m;
    m = g;
    if (md < 2'd3) m[2] = 4'd0;
    if (md < 2'd2) m[1] = 4'd0;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/guess_round_ctrl_if.sv
// Handshake/data bundle between the round controller, the target lookup and the player side.
`default_nettype none

interface guess_round_ctrl_if;
  logic       Start;
  logic [1:0] Max_digit_sel;
  logic       Submit;
  logic [3:0] Guess_digit_1;
  logic [3:0] Guess_digit_2;
  logic [3:0] Guess_digit_3;
  logic [3:0] Target_digit_1;
  logic [3:0] Target_digit_2;
  logic [3:0] Target_digit_3;
  logic [1:0] Max_digit;
  logic [2:0] round;
  logic       Result_valid;
  logic       Too_high;
  logic       Too_low;
  logic       Correct;
  logic       Invalid_guess;
  logic [2:0] Attempts;
  logic [1:0] Rounds_won;
  logic       Game_over;

  modport slave (
    input  Start, Max_digit_sel, Submit,
    input  Guess_digit_1, Guess_digit_2, Guess_digit_3,
    input  Target_digit_1, Target_digit_2, Target_digit_3,
    output Max_digit, round, Result_valid, Too_high, Too_low, Correct,
    output Invalid_guess, Attempts, Rounds_won, Game_over
  );

  modport master (
    output Start, Max_digit_sel, Submit,
    output Guess_digit_1, Guess_digit_2, Guess_digit_3,
    output Target_digit_1, Target_digit_2, Target_digit_3,
    input  Max_digit, round, Result_valid, Too_high, Too_low, Correct,
    input  Invalid_guess, Attempts, Rounds_won, Game_over
  );
endinterface

`default_nettype wire

// File: rtl/guess_round_ctrl_bcd3_compare.sv
// bcd3_compare: masks a 3-digit BCD guess to the difficulty, flags non-BCD digits, compares to target.
`default_nettype none

module bcd3_compare
  import guess_pkg::*;
(
  input  bcd3_t      guess,
  input  bcd3_t      target,
  input  logic [1:0] max_digit,
  output cmp_t       cmp,
  output logic       bcd_invalid
);

  bcd3_t masked;

  always_comb begin
    masked      = mask_digits(guess, max_digit);
    bcd_invalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (masked[i] > BCD_MAX) bcd_invalid = 1'b1;
    end
    // With 4-bit digits, a packed compare is the same as digit3-first lexicographic order.
    if (masked > target)      cmp = HIGH;
    else if (masked < target) cmp = LOW;
    else                      cmp = EQ;
  end

endmodule

`default_nettype wire

// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: game sequencer stepping rounds, judging BCD guesses and tracking attempts/wins.
`default_nettype none

module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter int NUM_ROUNDS   = 3,
  parameter int MAX_ATTEMPTS = 7
) (
  input  wire logic         Clk,
  input  wire logic         Reset_n,
  guess_round_ctrl_if.slave bus
);

  localparam logic [2:0] LAST_ROUND   = 3'(NUM_ROUNDS);
  localparam logic [2:0] LAST_ATTEMPT = 3'(MAX_ATTEMPTS);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_max_digit, w_max_digit_nxt;
  logic [2:0] r_round, w_round_nxt;
  logic [2:0] r_attempts, w_attempts_nxt;
  logic [1:0] r_won, w_won_nxt;
  logic       r_result_valid, w_result_valid_nxt;
  logic       r_too_high, w_too_high_nxt;
  logic       r_too_low, w_too_low_nxt;
  logic       r_correct, w_correct_nxt;
  logic       r_invalid, w_invalid_nxt;
  logic       r_game_over, w_game_over_nxt;
  logic       r_advance, w_advance_nxt;
  bcd3_t      r_guess, w_guess_nxt;
  cmp_t       r_cmp, w_cmp_nxt;

  bcd3_t      w_live_guess;
  bcd3_t      w_target;
  bcd3_t      w_cmp_guess;
  cmp_t       w_cmp;
  logic       w_bcd_invalid;
  logic [2:0] w_att_inc;
  logic [1:0] w_won_inc;

  assign w_live_guess = {bus.Guess_digit_3, bus.Guess_digit_2, bus.Guess_digit_1};
  assign w_target     = {bus.Target_digit_3, bus.Target_digit_2, bus.Target_digit_1};
  // One comparator serves both the validity check and the latched compare.
  assign w_cmp_guess  = (r_state == COMPARE) ? r_guess : w_live_guess;
  assign w_att_inc    = (r_attempts == LAST_ATTEMPT) ? r_attempts : r_attempts + 3'd1;
  assign w_won_inc    = (r_won == 2'd3) ? 2'd3 : r_won + 2'd1;

  bcd3_compare u_cmp (
    .guess       (w_cmp_guess),
    .target      (w_target),
    .max_digit   (r_max_digit),
    .cmp         (w_cmp),
    .bcd_invalid (w_bcd_invalid)
  );

  always_comb begin
    w_state_nxt        = r_state;
    w_max_digit_nxt    = r_max_digit;
    w_round_nxt        = r_round;
    w_attempts_nxt     = r_attempts;
    w_won_nxt          = r_won;
    w_result_valid_nxt = 1'b0;
    w_too_high_nxt     = r_too_high;
    w_too_low_nxt      = r_too_low;
    w_correct_nxt      = r_correct;
    w_invalid_nxt      = 1'b0;
    w_game_over_nxt    = r_game_over;
    w_advance_nxt      = r_advance;
    w_guess_nxt        = r_guess;
    w_cmp_nxt          = r_cmp;

    if (bus.Start) begin
      w_max_digit_nxt = (bus.Max_digit_sel == 2'd0) ? 2'd1 : bus.Max_digit_sel;
      w_round_nxt     = 3'd1;
      w_attempts_nxt  = 3'd0;
      w_won_nxt       = 2'd0;
      w_too_high_nxt  = 1'b0;
      w_too_low_nxt   = 1'b0;
      w_correct_nxt   = 1'b0;
      w_game_over_nxt = 1'b0;
      w_advance_nxt   = 1'b0;
      w_state_nxt     = LOAD;
    end else begin
      case (r_state)
        IDLE: ;
        LOAD: begin
          // A finished round is advanced here so its final Attempts stays visible one cycle.
          if (r_advance) begin
            w_round_nxt    = r_round + 3'd1;
            w_attempts_nxt = 3'd0;
            w_advance_nxt  = 1'b0;
          end
          w_state_nxt = WAIT_GUESS;
        end
        WAIT_GUESS: begin
          if (bus.Submit) begin
            if (w_bcd_invalid) begin
              w_invalid_nxt = 1'b1;
            end else begin
              w_guess_nxt = mask_digits(w_live_guess, r_max_digit);
              w_state_nxt = COMPARE;
            end
          end
        end
        COMPARE: begin
          w_cmp_nxt   = w_cmp;
          w_state_nxt = RESOLVE;
        end
        RESOLVE: begin
          w_result_valid_nxt = 1'b1;
          w_too_high_nxt     = (r_cmp == HIGH);
          w_too_low_nxt      = (r_cmp == LOW);
          w_correct_nxt      = (r_cmp == EQ);
          w_attempts_nxt     = w_att_inc;
          if (r_cmp == EQ) w_won_nxt = w_won_inc;
          if ((r_cmp == EQ) || (w_att_inc == LAST_ATTEMPT)) begin
            if (r_round < LAST_ROUND) begin
              w_advance_nxt = 1'b1;
              w_state_nxt   = LOAD;
            end else begin
              w_game_over_nxt = 1'b1;
              w_state_nxt     = DONE;
            end
          end else begin
            w_state_nxt = WAIT_GUESS;
          end
        end
        DONE: ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state        <= IDLE;
      r_max_digit    <= 2'd1;
      r_round        <= 3'd0;
      r_attempts     <= 3'd0;
      r_won          <= 2'd0;
      r_result_valid <= 1'b0;
      r_too_high     <= 1'b0;
      r_too_low      <= 1'b0;
      r_correct      <= 1'b0;
      r_invalid      <= 1'b0;
      r_game_over    <= 1'b0;
      r_advance      <= 1'b0;
      r_guess        <= '0;
      r_cmp          <= EQ;
    end else begin
      r_state        <= w_state_nxt;
      r_max_digit    <= w_max_digit_nxt;
      r_round        <= w_round_nxt;
      r_attempts     <= w_attempts_nxt;
      r_won          <= w_won_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_too_high     <= w_too_high_nxt;
      r_too_low      <= w_too_low_nxt;
      r_correct      <= w_correct_nxt;
      r_invalid      <= w_invalid_nxt;
      r_game_over    <= w_game_over_nxt;
      r_advance      <= w_advance_nxt;
      r_guess        <= w_guess_nxt;
      r_cmp          <= w_cmp_nxt;
    end
  end

  assign bus.Max_digit     = r_max_digit;
  assign bus.round         = r_round;
  assign bus.Result_valid  = r_result_valid;
  assign bus.Too_high      = r_too_high;
  assign bus.Too_low       = r_too_low;
  assign bus.Correct       = r_correct;
  assign bus.Invalid_guess = r_invalid;
  assign bus.Attempts      = r_attempts;
  assign bus.Rounds_won    = r_won;
  assign bus.Game_over     = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_guess_round_ctrl.sv
// Scoreboard bench for guess_round_ctrl with a small target lookup stand-in.
`default_nettype none

module tb_guess_round_ctrl;

  logic Clk;
  logic Reset_n;
  int   cyc;
  int   passed;
  int   total;

  guess_round_ctrl_if bus ();

  guess_round_ctrl #(.NUM_ROUNDS(3), .MAX_ATTEMPTS(7)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Stand-in for get_target_number: fixed targets per difficulty and round.
  function automatic logic [11:0] lookup(input logic [1:0] md, input logic [2:0] rnd);
    logic [11:0] t;
    t = 12'h000;
    case ({md, rnd})
      5'b01_001: t = 12'h002;
      5'b01_010: t = 12'h004;
      5'b01_011: t = 12'h006;
      5'b10_001: t = 12'h057;
      5'b10_010: t = 12'h030;
      5'b10_011: t = 12'h099;
      5'b11_001: t = 12'h123;
      5'b11_010: t = 12'h000;
      5'b11_011: t = 12'h999;
      default:   t = 12'h000;
    endcase
    return t;
  endfunction

  logic [11:0] tgt;
  always_comb begin
    tgt = lookup(bus.Max_digit, bus.round);
    bus.Target_digit_3 = tgt[11:8];
    bus.Target_digit_2 = tgt[7:4];
    bus.Target_digit_1 = tgt[3:0];
  end

  typedef struct {
    int   kind;   // 1 = compare result, 2 = invalid-guess pulse
    logic th;
    logic tl;
    logic cor;
    int   att;
    int   won;
    int   cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every result/invalid pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (bus.Result_valid || bus.Invalid_guess) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        int   act_kind;
        e = sb.pop_front();
        act_kind = (bus.Result_valid && !bus.Invalid_guess) ? 1 :
                   (bus.Invalid_guess && !bus.Result_valid) ? 2 : 3;
        check("out_kind", act_kind, e.kind);
        check("out_cycle", cyc, e.cyc);
        if (e.kind == 1) begin
          check("too_high", int'(bus.Too_high), int'(e.th));
          check("too_low", int'(bus.Too_low), int'(e.tl));
          check("correct", int'(bus.Correct), int'(e.cor));
        end
        check("attempts", int'(bus.Attempts), e.att);
        check("rounds_won", int'(bus.Rounds_won), e.won);
      end
    end
  end

  task automatic start_game(input logic [1:0] sel);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Max_digit_sel = sel;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  // kind 0: nothing expected; 1: result two edges later; 2: invalid pulse at the sampling edge.
  task automatic submit(input logic [3:0] g3, input logic [3:0] g2, input logic [3:0] g1,
                        input int kind, input logic th, input logic tl, input logic cor,
                        input int att, input int won);
    exp_t e;
    @(negedge Clk);
    if (kind != 0) begin
      e.kind = kind; e.th = th; e.tl = tl; e.cor = cor;
      e.att = att; e.won = won;
      e.cyc = cyc + ((kind == 1) ? 3 : 1);
      sb.push_back(e);
    end
    bus.Submit = 1'b1;
    bus.Guess_digit_3 = g3;
    bus.Guess_digit_2 = g2;
    bus.Guess_digit_1 = g1;
    @(negedge Clk);
    bus.Submit = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic check_status(input string tag, input int md, input int rnd, input int att,
                              input int won, input int go);
    check({tag, "_max_digit"}, int'(bus.Max_digit), md);
    check({tag, "_round"}, int'(bus.round), rnd);
    check({tag, "_attempts"}, int'(bus.Attempts), att);
    check({tag, "_rounds_won"}, int'(bus.Rounds_won), won);
    check({tag, "_game_over"}, int'(bus.Game_over), go);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    passed = 0;
    total  = 0;
    Reset_n = 1'b0;
    bus.Start = 1'b0;
    bus.Max_digit_sel = 2'd0;
    bus.Submit = 1'b0;
    bus.Guess_digit_1 = 4'd0;
    bus.Guess_digit_2 = 4'd0;
    bus.Guess_digit_3 = 4'd0;
    repeat (2) @(negedge Clk);
    check_status("reset", 1, 0, 0, 0, 0);
    check("reset_flags", int'({bus.Too_high, bus.Too_low, bus.Correct}), 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Single digit game: target 2.
    start_game(2'd1);
    check_status("start1", 1, 1, 0, 0, 0);
    submit(4'd0, 4'd0, 4'd5, 1, 1'b1, 1'b0, 1'b0, 1, 0);
    submit(4'd0, 4'd0, 4'd1, 1, 1'b0, 1'b1, 1'b0, 2, 0);
    submit(4'd0, 4'd0, 4'd2, 1, 1'b0, 1'b0, 1'b1, 3, 1);
    check_status("after_win1", 1, 2, 0, 1, 0);

    // Three digits, target 123, with a rejected non-BCD guess in between.
    start_game(2'd3);
    submit(4'd1, 4'd2, 4'd4, 1, 1'b1, 1'b0, 1'b0, 1, 0);
    submit(4'd1, 4'hA, 4'd3, 2, 1'b0, 1'b0, 1'b0, 1, 0);
    submit(4'd1, 4'd2, 4'd3, 1, 1'b0, 1'b0, 1'b1, 2, 1);

    // Two digits, target 57: seven misses lose the round.
    start_game(2'd2);
    for (int i = 1; i <= 7; i++) begin
      submit(4'd0, 4'd1, 4'd0, 1, 1'b0, 1'b1, 1'b0, i, 0);
    end
    check_status("round_lost", 2, 2, 0, 0, 0);
    check("round_lost_too_low_held", int'(bus.Too_low), 1);

    // Full game at three digits: 123, 000, 999.
    start_game(2'd3);
    submit(4'd1, 4'd2, 4'd3, 1, 1'b0, 1'b0, 1'b1, 1, 1);
    submit(4'd0, 4'd0, 4'd0, 1, 1'b0, 1'b0, 1'b1, 1, 2);
    submit(4'd9, 4'd9, 4'd9, 1, 1'b0, 1'b0, 1'b1, 1, 3);
    check_status("game_done", 3, 3, 1, 3, 1);
    submit(4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    check_status("done_ignores_submit", 3, 3, 1, 3, 1);
    start_game(2'd3);
    check_status("restart", 3, 1, 0, 0, 0);
    check("restart_correct_cleared", int'(bus.Correct), 0);

    // Start and Submit together: restart wins, no result.
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Max_digit_sel = 2'd3;
    bus.Submit = 1'b1;
    bus.Guess_digit_3 = 4'd1;
    bus.Guess_digit_2 = 4'd2;
    bus.Guess_digit_1 = 4'd3;
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.Submit = 1'b0;
    repeat (5) @(negedge Clk);
    check_status("start_over_submit", 3, 1, 0, 0, 0);
    submit(4'd1, 4'd2, 4'd4, 1, 1'b1, 1'b0, 1'b0, 1, 0);

    // Asynchronous reset while the guess is being compared.
    @(negedge Clk);
    bus.Submit = 1'b1;
    bus.Guess_digit_3 = 4'd1;
    bus.Guess_digit_2 = 4'd2;
    bus.Guess_digit_1 = 4'd3;
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check_status("async_reset", 1, 0, 0, 0, 0);
    check("async_reset_flags", int'({bus.Too_high, bus.Too_low, bus.Correct,
                                     bus.Result_valid, bus.Invalid_guess}), 0);
    @(negedge Clk);
    bus.Submit = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    submit(4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    check_status("idle_ignores_submit", 1, 0, 0, 0, 0);

    // Difficulty 0 maps to 1; upper non-BCD digits are masked away.
    start_game(2'd0);
    check_status("sel0", 1, 1, 0, 0, 0);
    submit(4'hF, 4'hF, 4'd2, 1, 1'b0, 1'b0, 1'b1, 1, 1);

    repeat (4) @(negedge Clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
